pc_redirect_ctrl: RTL

Sequencer that sits between the pipeline's redirect sources and the PC register. It arbitrates exception, eret, branch and jump requests by fixed priority and drives exactly one `take*` select plus its target payload into the PC. While fetch is stalled, it latches the winning redirect and issues it when the stall clears. It also generates IF/ID flushes and squashes wrong-path branch/jump requests for one cycle after an exception or eret.

---
 rtl/pc_redirect_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// Fixed-priority PC redirect sequencer with stall latching and wrong-path squash.
// Optional PC_REDIRECT_PERF_EN adds redirect/stall event counters.
module pc_redirect_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        excReq,
   input  logic        eretReq,
   input  logic [31:0] epcIn,
   input  logic        branchReq,
   input  logic [31:0] branchImmIn,
   input  logic        jumpRegReq,
   input  logic [31:0] jumpRegIn,
   input  logic        jumpImmReq,
   input  logic [25:0] jumpImmIn,
   output logic        takeException,
   output logic        takeEret,
   output logic        takeBranch,
   output logic        takeJumpReg,
   output logic        takeJumpImm,
   output logic [31:0] epc,
   output logic [31:0] branchImmEx,
   output logic [31:0] jumpReg,
   output logic [25:0] jumpImm,
   output logic        pcWe,
   output logic        flushIf,
   output logic        flushId,
   output logic        busy
`ifdef PC_REDIRECT_PERF_EN
   ,
   output logic [31:0] redirectCount,
   output logic [31:0] stallCount
`endif
);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] PEND   = 2'd1;
   localparam logic [1:0] SQUASH = 2'd2;

   // Kind codes are ordered so a larger value means higher priority.
   localparam logic [2:0] K_NONE = 3'd0;
   localparam logic [2:0] K_JI   = 3'd1;
   localparam logic [2:0] K_JR   = 3'd2;
   localparam logic [2:0] K_BR   = 3'd3;
   localparam logic [2:0] K_ERET = 3'd4;
   localparam logic [2:0] K_EXC  = 3'd5;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [2:0]  pend_kind;
   logic [2:0]  pend_kind_nxt;
   logic [31:0] pend_pay;
   logic [31:0] pend_pay_nxt;
   logic [2:0]  live_kind;
   logic [31:0] live_pay;
   logic [2:0]  win_kind;
   logic [31:0] win_pay;
   logic [2:0]  issue_kind;
   logic        wrong_path;
   logic        win_fatal;

   assign wrong_path = (state == SQUASH);

   always_comb begin
      live_kind = K_NONE;
      live_pay  = '0;
      if (excReq) begin
         live_kind = K_EXC;
      end else if (eretReq) begin
         live_kind = K_ERET;
         live_pay  = epcIn;
      end else if (branchReq && !wrong_path) begin
         live_kind = K_BR;
         live_pay  = branchImmIn;
      end else if (jumpRegReq && !wrong_path) begin
         live_kind = K_JR;
         live_pay  = jumpRegIn;
      end else if (jumpImmReq && !wrong_path) begin
         live_kind = K_JI;
         live_pay  = {6'b0, jumpImmIn};
      end
   end

   // A latched redirect survives unless a strictly higher one shows up.
   always_comb begin
      win_kind = live_kind;
      win_pay  = live_pay;
      if (state == PEND && pend_kind >= live_kind) begin
         win_kind = pend_kind;
         win_pay  = pend_pay;
      end
   end

   assign win_fatal  = (win_kind == K_EXC) || (win_kind == K_ERET);
   assign issue_kind = (rst || stall) ? K_NONE : win_kind;

   always_comb begin
      state_nxt     = state;
      pend_kind_nxt = pend_kind;
      pend_pay_nxt  = pend_pay;
      if (stall) begin
         if (win_kind != K_NONE) begin
            state_nxt     = PEND;
            pend_kind_nxt = win_kind;
            pend_pay_nxt  = win_pay;
         end else begin
            state_nxt = RUN;
         end
      end else begin
         pend_kind_nxt = K_NONE;
         pend_pay_nxt  = '0;
         state_nxt     = win_fatal ? SQUASH : RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         pend_kind <= K_NONE;
         pend_pay  <= '0;
      end else begin
         state     <= state_nxt;
         pend_kind <= pend_kind_nxt;
         pend_pay  <= pend_pay_nxt;
      end
   end

   assign takeException = (issue_kind == K_EXC);
   assign takeEret      = (issue_kind == K_ERET);
   assign takeBranch    = (issue_kind == K_BR);
   assign takeJumpReg   = (issue_kind == K_JR);
   assign takeJumpImm   = (issue_kind == K_JI);

   assign epc         = takeEret    ? win_pay       : '0;
   assign branchImmEx = takeBranch  ? win_pay       : '0;
   assign jumpReg     = takeJumpReg ? win_pay       : '0;
   assign jumpImm     = takeJumpImm ? win_pay[25:0] : '0;

   assign pcWe    = !rst && !stall;
   assign flushIf = takeException || takeEret || takeBranch
                    || takeJumpReg || takeJumpImm;
   assign flushId = takeException || takeEret;
   assign busy    = !rst && ((state == PEND)
                    || (stall && win_kind != K_NONE));

`ifdef PC_REDIRECT_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         redirectCount <= '0;
         stallCount    <= '0;
      end else begin
         if (flushIf) redirectCount <= redirectCount + 32'd1;
         if (stall)   stallCount    <= stallCount + 32'd1;
      end
   end
`else
`endif

endmodule
